// File: rtl/me_mv_select.sv
// Motion-vector selection: running-minimum SAD search over the raster candidate grid.
// Optional ME_ZERO_MV_BIAS_EN credits the (0,0) candidate by ZERO_BIAS before comparison.
module me_mv_select #(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int SAD_W      = 16,
  parameter int MV_W       = 7,
  parameter int ZERO_BIAS  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    sad_valid,
  input  logic [SAD_W-1:0]        sad,
  output logic                    busy,
  output logic                    done,
  output logic signed [MV_W-1:0]  mv_x,
  output logic signed [MV_W-1:0]  mv_y,
  output logic [SAD_W-1:0]        best_sad
);

  localparam int P   = SEARCH_DIM - MACRO_DIM + 1;
  localparam int OFF = (P - 1) / 2;
  localparam int CW  = $clog2(P + 1);

  localparam logic [CW-1:0] PM1   = CW'(P - 1);
  localparam logic [CW-1:0] OFF_C = CW'(OFF);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cx, cy, bx, by;
  logic [SAD_W-1:0] best;
  logic             first;

  logic [SAD_W-1:0] cand;
  logic             take;
  logic             last;
  logic [CW-1:0]    fx, fy;
  logic [SAD_W-1:0] fsad;

`ifdef ME_ZERO_MV_BIAS_EN
  localparam logic [SAD_W-1:0] ZB = SAD_W'(ZERO_BIAS);

  always_comb begin
    cand = sad;
    if (cx == OFF_C && cy == OFF_C)
      cand = (sad > ZB) ? sad - ZB : '0;
  end
`else
  logic unused_bias;
  assign unused_bias = ^ZERO_BIAS;

  always_comb cand = sad;
`endif

  assign take = sad_valid && (first || cand < best);
  assign last = (cx == PM1) && (cy == PM1);
  assign fx   = take ? cx : bx;
  assign fy   = take ? cy : by;
  assign fsad = take ? cand : best;

  assign busy = (state == SCAN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cx       <= '0;
      cy       <= '0;
      bx       <= '0;
      by       <= '0;
      best     <= '0;
      first    <= 1'b0;
      mv_x     <= '0;
      mv_y     <= '0;
      best_sad <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            cx    <= '0;
            cy    <= '0;
            first <= 1'b1;
          end
        end
        SCAN: begin
          if (start) begin
            cx    <= '0;
            cy    <= '0;
            first <= 1'b1;
          end else if (sad_valid) begin
            first <= 1'b0;
            if (take) begin
              best <= cand;
              bx   <= cx;
              by   <= cy;
            end
            if (last) begin
              state    <= DONE;
              cx       <= '0;
              cy       <= '0;
              mv_x     <= MV_W'(fx) - MV_W'(OFF);
              mv_y     <= MV_W'(fy) - MV_W'(OFF);
              best_sad <= fsad;
            end else if (cx == PM1) begin
              cx <= '0;
              cy <= cy + 1'b1;
            end else begin
              cx <= cx + 1'b1;
            end
          end
        end
        DONE: begin
          // A start here overlaps the done pulse and begins the next scan.
          if (start) begin
            state <= SCAN;
            cx    <= '0;
            cy    <= '0;
            first <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_mv_select.sv
// Self-checking bench for me_mv_select with a 5x5 candidate grid.
// Directed spec scenarios plus randomized scans checked against a behavioural model.
module tb_me_mv_select;

  localparam int N = 25;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              sad_valid = 1'b0;
  logic [15:0]       sad = '0;
  logic              busy;
  logic              done;
  logic signed [6:0] mv_x;
  logic signed [6:0] mv_y;
  logic [15:0]       best_sad;

  int checks = 0;
  int failures = 0;
  int done_seen;
  int s[N];
  int ex, ey, eb;

  me_mv_select #(
    .MACRO_DIM (16),
    .SEARCH_DIM(20),
    .SAD_W     (16),
    .MV_W      (7),
    .ZERO_BIAS (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sad_valid(sad_valid),
    .sad      (sad),
    .busy     (busy),
    .done     (done),
    .mv_x     (mv_x),
    .mv_y     (mv_y),
    .best_sad (best_sad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Best = first candidate in raster order holding the strictly smallest
  // (possibly centre-biased) SAD.
  task automatic model(input int v[N], output int mx, output int my,
                       output int mb);
    int c;
    mx = 0; my = 0; mb = 0;
    for (int i = 0; i < N; i++) begin
      c = v[i];
`ifdef ME_ZERO_MV_BIAS_EN
      if (i == 12) c = (c > 64) ? c - 64 : 0;
`endif
      if (i == 0 || c < mb) begin
        mb = c;
        mx = (i % 5) - 2;
        my = (i / 5) - 2;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (done) done_seen++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int v[N], input int cnt, input bit gaps);
    int g;
    for (int i = 0; i < cnt; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          sad_valid = 1'b0;
          tick();
        end
      end
      sad_valid = 1'b1;
      sad = 16'(v[i]);
      tick();
    end
    sad_valid = 1'b0;
  endtask

  // Feeds a full grid (start already issued), then checks the done cycle.
  task automatic scan(input string tag, input int v[N], input bit gaps,
                      input int mx, input int my, input int mb,
                      input bit chain);
    done_seen = 0;
    chk({tag, ".busy"}, int'(busy), 1);
    feed(v, N, gaps);
    chk({tag, ".early_done"}, done_seen, 1);
    chk({tag, ".done"}, int'(done), 1);
    chk({tag, ".mv_x"}, int'(mv_x), mx);
    chk({tag, ".mv_y"}, int'(mv_y), my);
    chk({tag, ".best_sad"}, int'(best_sad), mb);
    start = chain;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".done_clr"}, int'(done), 0);
    chk({tag, ".busy_after"}, int'(busy), int'(chain));
    chk({tag, ".hold_sad"}, int'(best_sad), mb);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.mv_x", int'(mv_x), 0);
    chk("rst.mv_y", int'(mv_y), 0);
    chk("rst.best_sad", int'(best_sad), 0);

    sad_valid = 1'b1;
    sad = 16'd1;
    @(negedge clk);
    sad_valid = 1'b0;
    chk("idle.ignore", int'(busy), 0);

    for (int i = 0; i < N; i++) s[i] = (i == 7) ? 10 : 100;
    pulse_start();
    scan("idx7", s, 1'b0, 0, -1, 10, 1'b0);

    for (int i = 0; i < N; i++) s[i] = 500;
    pulse_start();
    scan("tie", s, 1'b0, -2, -2, 500, 1'b0);

    for (int i = 0; i < N; i++) s[i] = (i == 24) ? 0 : 9;
    pulse_start();
    scan("last", s, 1'b0, 2, 2, 0, 1'b0);
    pulse_start();
    scan("last_gaps", s, 1'b1, 2, 2, 0, 1'b0);

    for (int i = 0; i < N; i++) s[i] = 1;
    pulse_start();
    done_seen = 0;
    feed(s, 10, 1'b0);
    for (int i = 0; i < N; i++) s[i] = (i == 0) ? 3 : 40 + i;
    start = 1'b1;
    sad_valid = 1'b1;
    sad = 16'd0;
    tick();
    start = 1'b0;
    sad_valid = 1'b0;
    scan("abort", s, 1'b0, -2, -2, 3, 1'b0);
    chk("abort.one_done", done_seen, 1);

    for (int i = 0; i < N; i++) s[i] = 2;
    pulse_start();
    done_seen = 0;
    feed(s, 12, 1'b0);
    rst = 1'b1;
    tick();
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    chk("midrst.mv_x", int'(mv_x), 0);
    chk("midrst.mv_y", int'(mv_y), 0);
    chk("midrst.best_sad", int'(best_sad), 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("midrst.no_done", done_seen, 0);

    for (int i = 0; i < N; i++) s[i] = 200;
    s[12] = 100;
    s[0] = 50;
    pulse_start();
`ifdef ME_ZERO_MV_BIAS_EN
    scan("bias", s, 1'b0, 0, 0, 36, 1'b1);
`else
    scan("bias", s, 1'b0, -2, -2, 50, 1'b1);
`endif

    // Previous scan chained a start on its done cycle; this scan rides it.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) s[i] = $urandom_range(0, 90);
      model(s, ex, ey, eb);
      scan($sformatf("rand%0d", r), s, r[0], ex, ey, eb, r < 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/me_mv_select.md
# me_mv_select

Motion-vector selection stage directly downstream of the SAD datapath in the inter-prediction path. Consumes one 16-bit SAD per cycle-qualified candidate, in raster order over the search window. Tracks the running minimum and its candidate coordinates, and emits the winning signed motion vector and its SAD once every candidate of the macroblock has been seen. Feeds the motion-compensation / mode-decision stage.

## Interface
Parameters:
- MACRO_DIM, 16, macroblock edge in pixels
- SEARCH_DIM, 48, search-window edge in pixels; P = SEARCH_DIM-MACRO_DIM+1 candidates per axis (33 by default)
- SAD_W, 16, SAD width
- MV_W, 7, signed MV component width; must satisfy 2^(MV_W-1) > (P-1)/2
- ZERO_BIAS, 64, SAD credit given to the (0,0) candidate (used only with the macro below)

Ports:
- clk, in, 1, sole clock, rising edge
- rst, in, 1, synchronous, active-high reset
- start, in, 1, one-cycle pulse: begin a new macroblock scan
- sad_valid, in, 1, sad carries the next candidate's SAD
- sad, in, SAD_W, candidate SAD, unsigned
- busy, out, 1, scan in progress
- done, out, 1, one-cycle pulse: results valid
- mv_x, out, MV_W, signed horizontal MV of the best candidate
- mv_y, out, MV_W, signed vertical MV of the best candidate
- best_sad, out, SAD_W, SAD of the best candidate (after bias, if enabled)

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: sad_valid is ignored. start moves the block to SCAN. On the same edge it clears the counters cx=cy=0 and sets first=1.
- SCAN: each cycle with sad_valid=1 is one candidate at (cx,cy).
  - Candidate MV is (cx-OFF, cy-OFF), with OFF=(P-1)/2.
  - If first=1 or sad < best: load best, bx, by. Then clear first.
  - Ties keep the earlier candidate. The comparison is strictly less-than, unsigned.
  - Counters: cx increments. At cx=P-1, cx wraps to 0 and cy increments.
  - When the accepted candidate is (P-1,P-1), the block goes to DONE.
- DONE: lasts one cycle. done=1 and the outputs update. Then the block returns to IDLE.
- Outputs mv_x, mv_y and best_sad are registered. They change only on entry to DONE and are held until the next DONE or reset.
- start while in SCAN aborts the scan and restarts it. Counters and first reset, and the previous partial result is discarded. If start and sad_valid arrive in the same cycle, start wins and the SAD is dropped.
- start in DONE is accepted: the block goes straight to SCAN, and the done pulse is still emitted that cycle.
- Gaps in sad_valid are allowed; the counters hold.
- busy=1 in SCAN only.

## Timing
- Reset values: busy=0, done=0, mv_x=0, mv_y=0, best_sad=0, state IDLE, counters 0.
- rst mid-scan returns to IDLE on the next edge with no done pulse.
- First sad_valid accepted: the cycle after start (busy=1).
- Latency: done rises one cycle after the edge that accepts the final candidate. Outputs are valid in that same cycle.
- Minimum scan length: P*P cycles of sad_valid. Minimum start-to-done: P*P+1 cycles.
- Throughput: one candidate per cycle. A new start may coincide with done.

## Configuration
- ME_ZERO_MV_BIAS_EN defined:
  - The candidate at MV (0,0) (cx=cy=OFF) is compared and stored using max(sad-ZERO_BIAS, 0). The subtraction saturates at 0.
  - best_sad reports the biased value.
- Undefined: all candidates are compared unmodified, and ZERO_BIAS is unused.

## Test plan
Use SEARCH_DIM=20, MACRO_DIM=16, so P=5, OFF=2 and there are 25 candidates.
- Reset then start with sad = 100 for every candidate except candidate index 7 (cx=2, cy=1), which gets 10. Expect done 1 cycle after the 25th sad_valid, with mv=(0,-1) and best_sad=10.
- All 25 SADs = 500 (tie). Expect mv=(-2,-2) and best_sad=500 (first candidate wins).
- Minimum at the last candidate (sad=0 at index 24, others 9). Expect mv=(2,2) and best_sad=0. Insert random sad_valid gaps and expect the same result.
- Abort: start, feed 10 SADs, pulse start again, feed 25 fresh SADs with the minimum 3 at index 0. Expect exactly one done, with mv=(-2,-2).
- rst asserted after 12 candidates. Expect busy=0 and all outputs 0 next cycle, and no done.
- With ME_ZERO_MV_BIAS_EN and ZERO_BIAS=64: center SAD 100, index 0 SAD 50, others 200. Expect mv=(0,0) and best_sad=36. Without the macro, expect mv=(-2,-2) and best_sad=50.
